pico_input_handshake: RTL and testbench

//   Producer side of the picoMIPS stall/release handshake. While the decoder holds the
//   PC stalled (PCincr low), this block waits for a clean, debounced press of the user

---
 rtl/picomips_pkg.sv | 15 +
 rtl/pico_input_handshake_btn_debounce.sv | 40 ++++
 rtl/pico_input_handshake.sv | 76 +++++++
 tb/tb_pico_input_handshake.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/picomips_pkg.sv
// Shared types and defaults for the picoMIPS stall/release input handshake.
package picomips_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOW,
    WAIT_HIGH,
    FIRE,
    WAIT_REL
  } hs_state_t;

  localparam int unsigned DB_CYCLES_DEFAULT = 4;
  localparam int unsigned N_DEFAULT         = 8;

endpackage

// File: rtl/pico_input_handshake_btn_debounce.sv
// Two-flop synchroniser plus run-length debounce of the raw button level.
module btn_debounce
  import picomips_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic db_level
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // A new level is accepted only after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      cnt      <= '0;
      db_level <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      if (s2 == db_level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        db_level <= s2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pico_input_handshake.sv
// Waits for a debounced button press while the PC is stalled, captures the switches
// and emits a single-cycle release flag.
module pico_input_handshake
  import picomips_pkg::*;
#(
  parameter int unsigned N         = N_DEFAULT,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall_req,
  input  logic         btn,
  input  logic [N-1:0] sw_data,
  output logic         flag,
  output logic [N-1:0] data_out,
  output logic         waiting
);

  hs_state_t state;
  hs_state_t next_state;
  logic      db_level;
  logic      capture_c;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .reset   (reset),
    .btn     (btn),
    .db_level(db_level)
  );

  // A press is only honoured after the button has been seen released within the stall.
  always_comb begin
    next_state = state;
    capture_c  = 1'b0;
    case (state)
      IDLE: begin
        if (stall_req) next_state = db_level ? WAIT_LOW : WAIT_HIGH;
      end
      WAIT_LOW: begin
        if (!stall_req)     next_state = IDLE;
        else if (!db_level) next_state = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (!stall_req) begin
          next_state = IDLE;
        end else if (db_level) begin
          next_state = FIRE;
          capture_c  = 1'b1;
        end
      end
      FIRE:     next_state = WAIT_REL;
      WAIT_REL: begin
        if (!db_level) next_state = IDLE;
      end
      default:  next_state = IDLE;
    endcase
  end

  // Outputs are flops loaded from the next state, so they track state with no input path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      flag     <= 1'b0;
      waiting  <= 1'b0;
      data_out <= '0;
    end else begin
      state   <= next_state;
      flag    <= (next_state == FIRE);
      waiting <= (next_state == WAIT_LOW) || (next_state == WAIT_HIGH);
      if (capture_c) data_out <= sw_data;
    end
  end

endmodule

// File: tb/tb_pico_input_handshake.sv
// Randomised and directed bench for pico_input_handshake against a behavioural model.
module tb_pico_input_handshake;

  localparam int unsigned N  = 8;
  localparam int unsigned DB = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         stall_req;
  logic         btn;
  logic [N-1:0] sw_data;
  logic         flag;
  logic [N-1:0] data_out;
  logic         waiting;

  int n_tests = 0;
  int n_fail  = 0;
  int dut_flags = 0;
  int m_flags   = 0;

  // Model: "armed" means a stall is pending; "need_low" means a release must be seen first.
  bit         m_armed, m_need_low, m_fire, m_held, m_db;
  logic [N-1:0] m_data;
  bit         hist[$];

  pico_input_handshake #(.N(N), .DB_CYCLES(DB)) dut (
    .clk      (clk),
    .reset    (reset),
    .stall_req(stall_req),
    .btn      (btn),
    .sw_data  (sw_data),
    .flag     (flag),
    .data_out (data_out),
    .waiting  (waiting)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_need_low = 0; m_fire = 0; m_held = 0; m_db = 0;
    m_data = '0;
    hist.delete();
    repeat (DB + 2) hist.push_back(1'b0);
  endtask

  // The accepted level flips once the last DB synchronised samples all disagree with it.
  function automatic bit level_flips();
    for (int i = 0; i < int'(DB); i++)
      if (hist[hist.size() - 3 - i] == m_db) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    if (reset) begin
      model_reset();
    end else begin
      if (m_fire) begin
        m_fire = 0;
        m_held = 1;
      end else if (m_held) begin
        if (!m_db) m_held = 0;
      end else if (m_armed) begin
        if (!stall_req)      m_armed = 0;
        else if (m_need_low) m_need_low = !m_db ? 1'b0 : 1'b1;
        else if (m_db) begin
          m_armed = 0;
          m_fire  = 1;
          m_data  = sw_data;
        end
      end else if (stall_req) begin
        m_armed    = 1;
        m_need_low = m_db;
      end
      hist.push_back(btn);
      if (level_flips()) m_db = !m_db;
      if (hist.size() > 32) void'(hist.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    if (m_fire) m_flags++;
    #1;
    if (flag) dut_flags++;
    chk("flag", flag, m_fire);
    chk("waiting", waiting, m_armed);
    chk("data_out", data_out, m_data);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_flag", flag, 1'b0);
    chk("rst_waiting", waiting, 1'b0);
    chk("rst_data", data_out, 0);
    ticks(2);
    reset = 1'b0;
  endtask

  initial begin
    int lat;
    int f0;
    int presses;
    logic [N-1:0] d0;

    reset = 1'b1; stall_req = 1'b0; btn = 1'b0; sw_data = '0;
    model_reset();
    ticks(3);
    reset = 1'b0;
    ticks(2);

    // Normal press: latency from button edge to flag, capture value
    stall_req = 1'b1; sw_data = 8'hA5;
    ticks(2);
    chk("t2_waiting", waiting, 1'b1);
    btn = 1'b1;
    lat = 0;
    for (int i = 0; i < 20 && !flag; i++) begin
      tick();
      lat++;
    end
    chk("t2_latency", lat, DB + 3);
    chk("t2_data", data_out, 8'hA5);
    chk("t2_waiting_fell", waiting, 1'b0);
    tick();
    chk("t2_flag_one_cycle", flag, 1'b0);
    btn = 1'b0;
    ticks(10);
    stall_req = 1'b0;
    ticks(3);

    // Short glitch while waiting for a press
    stall_req = 1'b1; sw_data = 8'h11;
    ticks(2);
    f0 = dut_flags;
    btn = 1'b1; ticks(3);
    btn = 1'b0; ticks(10);
    chk("t3_waiting", waiting, 1'b1);
    chk("t3_noflag", dut_flags, f0);
    stall_req = 1'b0;
    ticks(3);

    // Button already held when the stall begins
    btn = 1'b1; ticks(10);
    f0 = dut_flags;
    stall_req = 1'b1; sw_data = 8'h5A;
    ticks(10);
    chk("t4_held_noflag", dut_flags, f0);
    chk("t4_waiting", waiting, 1'b1);
    btn = 1'b0; ticks(8);
    btn = 1'b1; ticks(10);
    chk("t4_one_flag", dut_flags, f0 + 1);
    chk("t4_data", data_out, 8'h5A);
    btn = 1'b0; stall_req = 1'b0;
    ticks(10);

    // Abort on the same edge the debounced level is seen high
    stall_req = 1'b1;
    ticks(3);
    d0 = data_out;
    sw_data = 8'h3C;
    btn = 1'b1;
    ticks(6);
    stall_req = 1'b0;
    tick();
    chk("t5_flag", flag, 1'b0);
    chk("t5_waiting", waiting, 1'b0);
    chk("t5_data", data_out, d0);
    btn = 1'b0;
    ticks(10);

    // Reset during WAIT_REL with button held, then a fresh stall
    stall_req = 1'b1; sw_data = 8'hC3;
    ticks(2);
    btn = 1'b1;
    ticks(DB + 4);
    do_reset();
    stall_req = 1'b0;
    ticks(10);
    f0 = dut_flags;
    stall_req = 1'b1;
    ticks(6);
    chk("t6_held_noflag", dut_flags, f0);
    btn = 1'b0; ticks(8);
    btn = 1'b1; ticks(10);
    chk("t6_one_flag", dut_flags, f0 + 1);
    btn = 1'b0; stall_req = 1'b0;
    ticks(10);

    // Random presses with stall activity and occasional resets
    presses = 0;
    f0 = dut_flags;
    for (int p = 0; p < 100; p++) begin
      stall_req = ($urandom_range(0, 3) != 0);
      sw_data   = N'($urandom);
      btn = 1'b1;
      presses++;
      repeat ($urandom_range(1, 12)) begin
        tick();
        if ($urandom_range(0, 9) == 0) stall_req = !stall_req;
      end
      btn = 1'b0;
      repeat ($urandom_range(1, 12)) begin
        tick();
        if ($urandom_range(0, 9) == 0) stall_req = !stall_req;
      end
      if ($urandom_range(0, 24) == 0) do_reset();
    end
    chk("rand_flag_total", dut_flags, m_flags);
    chk("rand_flags_le_presses", (dut_flags - f0) <= presses, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
